jt6295_sched: RTL and testbench
===============================

JT6295_SCHED -- requirements
Module: jt6295_sched

Interface
REQ-001 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port cen  input  1  sample-rate strobe, always coincident with a cen4 pulse.
REQ-004 SHALL have port cen4  input  1  slot strobe, 4 per sample.
REQ-005 SHALL have port ch_start  input  4  one-cycle start pulse per channel.
REQ-006 SHALL have port ch_stop  input  4  one-cycle stop pulse per channel.
REQ-007 SHALL have port start_addr  input  18  first byte address for the started channel.
REQ-008 SHALL have port end_addr  input  18  last byte address for the started channel.
REQ-009 SHALL have port busy  output  4  channel playing.
REQ-010 SHALL have port slot  output  2  channel owning the current slot, for the accumulator.
REQ-011 SHALL have port rom_addr  output  18  ROM byte address.
REQ-012 SHALL have port rom_cs  output  1  ROM request, held until rom_ok or abort.
REQ-013 SHALL have port rom_data  input  8  ROM byte, valid with rom_ok.
REQ-014 SHALL have port rom_ok  input  1  ROM acknowledge.
REQ-015 SHALL have ports nibble (output, 4, ADPCM code for slot) and nibble_vld (output, 1, one-cycle qualifier).
REQ-016 SHALL have port overrun  output  1  one-cycle pulse on a missed fetch.

Function
REQ-017 SHALL keep per-channel 19-bit nibble pointer ptr (byte = ptr[18:1], half = ptr[0]), 18-bit end address and busy bit.
REQ-018 SHALL advance slot on cen4: cen forces slot 0, otherwise slot+1 mod 4.
REQ-019 SHALL use FSM IDLE/FETCH; on cen4, go to FETCH with rom_cs=1 and rom_addr=ptr[18:1] of the new slot if that channel is busy, else IDLE with rom_cs=0.
REQ-020 SHALL, in FETCH on rom_ok: drive nibble = rom_data[7:4] if ptr[0]=0 else rom_data[3:0], pulse nibble_vld the next cycle, increment ptr, drop rom_cs and return to IDLE.
REQ-021 SHALL clear busy on the completion that consumes the low nibble (ptr[0]=1) of byte end_addr.
REQ-022 SHALL, on cen4 while in FETCH with no rom_ok that cycle, pulse overrun, leave ptr unchanged and start the next slot per REQ-019.
REQ-023 SHALL treat rom_ok and cen4 in the same cycle as completion of the old slot first, then start of the new slot.
REQ-024 SHALL, on ch_start[n]: ptr_n <= {start_addr,1'b0}, end_n <= end_addr, busy[n] <= 1; with multiple bits set, the lowest index wins and the others are ignored.
REQ-025 SHALL, on ch_stop[n], clear busy[n] next cycle; stop beats start on the same channel in the same cycle.
REQ-026 SHALL, on start or stop of the channel in FETCH, abort the fetch: drop rom_cs, no nibble_vld, no ptr update.
REQ-027 SHALL ignore rom_ok when in IDLE.

Reset
REQ-028 SHALL reset busy=0, slot=3, FSM=IDLE, rom_cs=0, rom_addr=0, nibble=0, nibble_vld=0, overrun=0, all ptr/end=0.
REQ-029 SHALL abandon an in-flight fetch on reset mid-operation, with no nibble_vld after release.

Configuration
REQ-030 SHALL, with JT6295_SCHED_STATS_EN defined, add output ovr_cnt (8 bits), counting overrun pulses, saturating at 255 and reset to 0.
REQ-031 SHALL, without JT6295_SCHED_STATS_EN, omit ovr_cnt and its logic; all other behaviour is identical.

Structure
REQ-032 SHALL take channel count (4), address width (18) and the FSM state type from shared package jt6295_pkg.
REQ-033 SHALL instantiate sub-module jt6295_sched_ptr once per channel, holding ptr/end/busy with load, increment and end-detect logic.

Verification
REQ-034 SHALL check: reset, then cen with no channel busy -> slot=0, rom_cs stays 0, no nibble_vld.
REQ-035 SHALL check: start ch1 at 0x00100, end 0x00100, ROM returns 0xA5 in 3 cycles -> nibbles 0xA then 0x5 in consecutive ch1 slots, then busy[1]=0.
REQ-036 SHALL check: ROM never acks on ch2 slot -> overrun pulse at next cen4, and the next ch2 slot re-requests the same rom_addr.
REQ-037 SHALL check: rom_ok coincident with cen4 -> nibble_vld for the old slot, and rom_cs stays high for a busy next slot with the new address.
REQ-038 SHALL check: ch_start=4'b0110 -> only ch1 busy; ch_stop[0] during a ch0 fetch -> rom_cs drops, no nibble_vld.
REQ-039 SHALL check: with JT6295_SCHED_STATS_EN, 300 overruns -> ovr_cnt=255.

Source files
------------

// File: rtl/jt6295_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt6295_pkg
// Purpose  : Shared constants and types for the jt6295 channel scheduler:
//            channel count, ROM address width, slot width and FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package jt6295_pkg;

    localparam int NCH = 4;       // playback channels
    localparam int AW  = 18;      // ROM byte address width
    localparam int SW  = 2;       // slot index width (log2 of NCH)

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // Isolates the lowest set bit so that simultaneous start requests
    // resolve to the lowest channel index.
    function automatic logic [NCH-1:0] lowest_bit(input logic [NCH-1:0] v);
        return v & (~v + 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt6295_sched_ptr.sv
`default_nettype none
// ============================================================================
// Module   : jt6295_sched_ptr
// Purpose  : Per-channel playback state: 19-bit nibble pointer, end byte
//            address and busy flag, with load, increment and end detection.
//            Also exposes the next-cycle values so the scheduler can start a
//            fetch with state updated in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module jt6295_sched_ptr
    import jt6295_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_stop,
    input  logic          i_inc,
    input  logic [AW-1:0] i_start_addr,
    input  logic [AW-1:0] i_end_addr,
    output logic          o_busy,
    output logic          o_half,
    output logic          o_busy_nxt,
    output logic [AW-1:0] o_addr_nxt
);

    logic [AW:0]   r_ptr;
    logic [AW-1:0] r_end;
    logic          r_busy;

    logic [AW:0]   w_ptr_nxt;
    logic [AW-1:0] w_end_nxt;
    logic          w_busy_nxt;

    // Next-state: increment (with end detect on the low nibble of the last
    // byte), then load, then stop so that stop has the final word.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_end_nxt  = r_end;
        w_busy_nxt = r_busy;
        if (i_inc) begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr[0] && (r_ptr[AW:1] == r_end)) begin
                w_busy_nxt = 1'b0;
            end
        end
        if (i_load) begin
            w_ptr_nxt  = {i_start_addr, 1'b0};
            w_end_nxt  = i_end_addr;
            w_busy_nxt = 1'b1;
        end
        if (i_stop) begin
            w_busy_nxt = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_end  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_end  <= w_end_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_half     = r_ptr[0];
    assign o_busy_nxt = w_busy_nxt;
    assign o_addr_nxt = w_ptr_nxt[AW:1];

endmodule
`default_nettype wire

// File: rtl/jt6295_sched.sv
`default_nettype none
// ============================================================================
// Module   : jt6295_sched
// Purpose  : Time-slot scheduler for four ADPCM channels. Each cen4 slot
//            issues one ROM byte fetch for the owning channel and returns the
//            selected nibble; a fetch still pending at the next cen4 is
//            reported as an overrun and retried on the channel's next slot.
// Options  : JT6295_SCHED_STATS_EN adds the saturating ovr_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module jt6295_sched
    import jt6295_pkg::*;
(
    input  logic           rst,
    input  logic           clk,
    input  logic           cen,
    input  logic           cen4,
    input  logic [NCH-1:0] ch_start,
    input  logic [NCH-1:0] ch_stop,
    input  logic [AW-1:0]  start_addr,
    input  logic [AW-1:0]  end_addr,
    output logic [NCH-1:0] busy,
    output logic [SW-1:0]  slot,
    output logic [AW-1:0]  rom_addr,
    output logic           rom_cs,
    input  logic [7:0]     rom_data,
    input  logic           rom_ok,
    output logic [3:0]     nibble,
    output logic           nibble_vld,
    output logic           overrun
`ifdef JT6295_SCHED_STATS_EN
    ,
    output logic [7:0]     ovr_cnt
`endif
);

    state_t         r_state;
    logic [SW-1:0]  r_slot;
    logic [AW-1:0]  r_addr;
    logic           r_cs;
    logic [3:0]     r_nib;
    logic           r_vld;
    logic           r_ovr;

    logic [NCH-1:0] w_start_sel;
    logic [NCH-1:0] w_load;
    logic [NCH-1:0] w_inc;
    logic [NCH-1:0] w_busy;
    logic [NCH-1:0] w_busy_nxt;
    logic [NCH-1:0] w_half;
    logic [AW-1:0]  w_addr_nxt [NCH];
    logic           w_fetch;
    logic           w_abort;
    logic           w_done;
    logic           w_ovr;
    logic [SW-1:0]  w_slot_nxt;

    assign w_start_sel = lowest_bit(ch_start);
    assign w_load      = w_start_sel & ~ch_stop;
    assign w_fetch     = (r_state == ST_FETCH);
    // A start or stop touching the fetching channel cancels the fetch.
    assign w_abort     = w_fetch & (w_start_sel[r_slot] | ch_stop[r_slot]);
    assign w_done      = w_fetch & rom_ok & ~w_abort;
    assign w_ovr       = w_fetch & cen4 & ~rom_ok & ~w_abort;
    assign w_slot_nxt  = cen ? '0 : r_slot + 1'b1;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        assign w_inc[n] = w_done & (r_slot == SW'(n));

        jt6295_sched_ptr u_ptr (
            .clk          (clk),
            .rst          (rst),
            .i_load       (w_load[n]),
            .i_stop       (ch_stop[n]),
            .i_inc        (w_inc[n]),
            .i_start_addr (start_addr),
            .i_end_addr   (end_addr),
            .o_busy       (w_busy[n]),
            .o_half       (w_half[n]),
            .o_busy_nxt   (w_busy_nxt[n]),
            .o_addr_nxt   (w_addr_nxt[n])
        );
    end

    // Slot FSM: completion of the old slot is taken first, then cen4 decides
    // whether the new slot fetches using that channel's updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_slot  <= '1;
            r_addr  <= '0;
            r_cs    <= 1'b0;
            r_nib   <= '0;
            r_vld   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_vld <= w_done;
            r_ovr <= w_ovr;
            if (w_done) begin
                r_nib <= w_half[r_slot] ? rom_data[3:0] : rom_data[7:4];
            end
            if (cen4) begin
                r_slot <= w_slot_nxt;
                if (w_busy_nxt[w_slot_nxt]) begin
                    r_state <= ST_FETCH;
                    r_cs    <= 1'b1;
                    r_addr  <= w_addr_nxt[w_slot_nxt];
                end else begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                end
            end else if (w_done || w_abort) begin
                r_state <= ST_IDLE;
                r_cs    <= 1'b0;
            end
        end
    end

`ifdef JT6295_SCHED_STATS_EN
    logic [7:0] r_ovr_cnt;

    // Saturating count of overrun events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`endif

    assign busy       = w_busy;
    assign slot       = r_slot;
    assign rom_addr   = r_addr;
    assign rom_cs     = r_cs;
    assign nibble     = r_nib;
    assign nibble_vld = r_vld;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_jt6295_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt6295_sched
// Purpose  : Self-checking bench for jt6295_sched: directed scenarios plus a
//            randomized run, all compared each cycle against a behavioural
//            reference model with a latency-programmable ROM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt6295_sched;

    logic        rst, clk, cen, cen4;
    logic [3:0]  ch_start, ch_stop;
    logic [17:0] start_addr, end_addr;
    logic [3:0]  busy;
    logic [1:0]  slot;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [3:0]  nibble;
    logic        nibble_vld, overrun;
`ifdef JT6295_SCHED_STATS_EN
    logic [7:0]  ovr_cnt;
`endif

    jt6295_sched u_dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .cen4       (cen4),
        .ch_start   (ch_start),
        .ch_stop    (ch_stop),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .slot       (slot),
        .rom_addr   (rom_addr),
        .rom_cs     (rom_cs),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .nibble     (nibble),
        .nibble_vld (nibble_vld),
        .overrun    (overrun)
`ifdef JT6295_SCHED_STATS_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem [0:262143];

    // reference model state
    int m_ptr [4];
    int m_end [4];
    bit m_busy [4];
    int m_slot, m_addr, m_nib, m_cnt;
    bit m_fetch, m_cs, m_vld, m_ovr;

    // stimulus / responder state
    int tick, c4n, w_cnt, lat, lat_fixed, prev_slot;
    bit noack [4];
    bit spur_en;
    int ovr_seen, coinc;
    bit prev_req2;
    int nq[$];
    int rq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_ptr[i] = 0; m_end[i] = 0; m_busy[i] = 0;
        end
        m_slot = 3; m_addr = 0; m_nib = 0; m_cnt = 0;
        m_fetch = 0; m_cs = 0; m_vld = 0; m_ovr = 0;
    endtask

    // One clock of scheduler behaviour from the inputs present at the edge.
    task automatic model_step();
        int sel, p, d;
        bit abort, done;
        sel = -1;
        for (int i = 3; i >= 0; i--) if (ch_start[i]) sel = i;
        abort = m_fetch && ((sel == m_slot) || ch_stop[m_slot]);
        done  = m_fetch && rom_ok && !abort;
        m_vld = 0;
        m_ovr = 0;
        if (done) begin
            p = m_ptr[m_slot];
            d = int'(rom_data);
            m_nib = (p % 2 == 1) ? d % 16 : d / 16;
            m_vld = 1;
            if ((p % 2 == 1) && (p / 2 == m_end[m_slot])) m_busy[m_slot] = 0;
            m_ptr[m_slot] = (p + 1) % 524288;
        end
        if (m_fetch && cen4 && !rom_ok && !abort) begin
            m_ovr = 1;
            if (m_cnt < 255) m_cnt++;
        end
        if (sel >= 0 && !ch_stop[sel]) begin
            m_ptr[sel]  = 2 * int'(start_addr);
            m_end[sel]  = int'(end_addr);
            m_busy[sel] = 1;
        end
        for (int i = 0; i < 4; i++) if (ch_stop[i]) m_busy[i] = 0;
        if (cen4) begin
            m_slot  = cen ? 0 : (m_slot + 1) % 4;
            m_fetch = m_busy[m_slot];
            m_cs    = m_fetch;
            if (m_fetch) m_addr = m_ptr[m_slot] / 2;
        end else if (done || abort) begin
            m_fetch = 0;
            m_cs    = 0;
        end
    endtask

    task automatic compare();
        logic [3:0] bv;
        bit req2;
        for (int i = 0; i < 4; i++) bv[i] = m_busy[i];
        check("busy", 32'(busy), 32'(bv));
        check("slot", 32'(slot), m_slot);
        check("rom_cs", 32'(rom_cs), 32'(m_cs));
        if (m_cs) check("rom_addr", 32'(rom_addr), m_addr);
        check("nibble_vld", 32'(nibble_vld), 32'(m_vld));
        if (m_vld) check("nibble", 32'(nibble), m_nib);
        check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef JT6295_SCHED_STATS_EN
        check("ovr_cnt", 32'(ovr_cnt), m_cnt);
`endif
        if (overrun) ovr_seen++;
        if (nibble_vld) nq.push_back(int'(nibble));
        if (nibble_vld && cen4 && rom_cs) coinc++;
        req2 = rom_cs && (slot == 2'd2);
        if (req2 && !prev_req2) rq.push_back(int'(rom_addr));
        prev_req2 = req2;
    endtask

    // ROM responder: acknowledges after lat cycles unless the slot's channel
    // is marked as never answered; may inject stray acks while idle.
    task automatic respond();
        if (rom_ok) w_cnt = 0;
        rom_ok = 1'b0;
        if (rom_cs) begin
            if (int'(slot) != prev_slot) w_cnt = 0;
            if (w_cnt == 0) lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
            w_cnt++;
            if (!noack[slot] && w_cnt >= lat) begin
                rom_ok   = 1'b1;
                rom_data = mem[rom_addr];
            end
        end else begin
            w_cnt = 0;
            if (spur_en && $urandom_range(0, 7) == 0) begin
                rom_ok   = 1'b1;
                rom_data = 8'($urandom);
            end
        end
        prev_slot = int'(slot);
    endtask

    task automatic cycle();
        cen4 = (tick % 8 == 7);
        cen  = cen4 && (c4n % 4 == 3);
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (cen) check("cen_slot0", 32'(slot), 0);
        tick++;
        if (cen4) c4n++;
        ch_start = '0;
        ch_stop  = '0;
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_start = '0; ch_stop = '0; rom_ok = 1'b0; cen = 1'b0; cen4 = 1'b0;
        for (int i = 0; i < 4; i++) noack[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick = 0; c4n = 0; w_cnt = 0; prev_slot = 3; prev_req2 = 0;
        compare();
        check("rst_slot", 32'(slot), 3);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_nibble", 32'(nibble), 0);
    endtask

    task automatic wait_cs(input int ch);
        int n;
        n = 0;
        while (!(rom_cs && slot == 2'(ch)) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) check("wait_cs_timeout", 32'(n), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        mem[18'h00100] = 8'hA5;
        rst = 1'b1; cen = 0; cen4 = 0; ch_start = '0; ch_stop = '0;
        start_addr = '0; end_addr = '0; rom_data = '0; rom_ok = 0;
        lat_fixed = 3; spur_en = 0; ovr_seen = 0; coinc = 0;
        #3;

        // idle after reset: cen forces slot 0, no fetch activity
        do_reset();
        repeat (40) cycle();

        // single byte on channel 1: high then low nibble, then idle
        lat_fixed = 3;
        nq.delete();
        ch_start = 4'b0010; start_addr = 18'h00100; end_addr = 18'h00100;
        cycle();
        repeat (120) cycle();
        check("ch1_nib_count", 32'(nq.size()), 2);
        if (nq.size() >= 2) begin
            check("ch1_nib0", 32'(nq[0]), 32'hA);
            check("ch1_nib1", 32'(nq[1]), 32'h5);
        end
        check("ch1_done_busy", 32'(busy[1]), 0);

        // unanswered fetch on channel 2: overrun and identical re-request
        do_reset();
        lat_fixed = 3; noack[2] = 1; ovr_seen = 0; rq.delete();
        ch_start = 4'b0100; start_addr = 18'h02000; end_addr = 18'h02010;
        cycle();
        repeat (80) cycle();
        check("ch2_overruns", 32'(ovr_seen >= 2), 1);
        check("ch2_req_count", 32'(rq.size() >= 2), 1);
        if (rq.size() >= 2) begin
            check("ch2_req0", 32'(rq[0]), 32'h02000);
            check("ch2_req1", 32'(rq[1]), 32'h02000);
        end

        // ack landing on cen4 with the next slot busy
        do_reset();
        lat_fixed = 8; coinc = 0;
        ch_start = 4'b0010; start_addr = 18'h00300; end_addr = 18'h003FF;
        cycle();
        ch_start = 4'b0100; start_addr = 18'h00400; end_addr = 18'h004FF;
        cycle();
        repeat (200) cycle();
        check("coincident_seen", 32'(coinc > 0), 1);

        // multiple starts resolve to lowest; stop aborts an in-flight fetch
        do_reset();
        lat_fixed = 20;
        ch_start = 4'b0110; start_addr = 18'h00500; end_addr = 18'h005FF;
        cycle();
        check("multi_start", 32'(busy), 32'b0010);
        ch_start = 4'b0001; start_addr = 18'h00600; end_addr = 18'h006FF;
        cycle();
        wait_cs(0);
        rom_ok = 1'b1; rom_data = 8'h3C; ch_stop = 4'b0001;
        cycle();
        check("stop_cs", 32'(rom_cs), 0);
        check("stop_vld", 32'(nibble_vld), 0);
        check("stop_busy", 32'(busy[0]), 0);
        cycle();
        check("stop_vld_late", 32'(nibble_vld), 0);

        // reset in the middle of a fetch
        do_reset();
        lat_fixed = 20;
        ch_start = 4'b1000; start_addr = 18'h00700; end_addr = 18'h0070F;
        cycle();
        wait_cs(3);
        cycle();
        do_reset();
        rom_ok = 1'b1; rom_data = 8'h99;
        cycle();
        check("post_rst_vld", 32'(nibble_vld), 0);
        repeat (10) cycle();

        // randomized traffic
        do_reset();
        lat_fixed = 0; spur_en = 1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 31) == 0) begin
                ch_start   = 4'($urandom);
                start_addr = 18'($urandom);
                end_addr   = start_addr + 18'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 63) == 0) ch_stop = 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                int c;
                c = int'($urandom_range(0, 3));
                noack[c] = !noack[c];
            end
            cycle();
        end
        spur_en = 0;

`ifdef JT6295_SCHED_STATS_EN
        // overrun counter saturation
        do_reset();
        lat_fixed = 0; ovr_seen = 0;
        for (int i = 0; i < 4; i++) noack[i] = 1;
        for (int i = 0; i < 4; i++) begin
            ch_start   = 4'(1 << i);
            start_addr = 18'(i * 18'h01000);
            end_addr   = 18'(i * 18'h01000 + 18'h00FFF);
            cycle();
        end
        for (int k = 0; k < 4000 && ovr_seen < 300; k++) cycle();
        check("ovr_300_reached", 32'(ovr_seen >= 300), 1);
        check("ovr_cnt_sat", 32'(ovr_cnt), 255);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
